// File: rtl/load_store_unit.sv
// Load/store unit between the core and a byte-addressed, word-wide memory (sub-word stores via read-modify-write).
// Optional misalignment rejection is compiled in with `define LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
  localparam logic [2:0]  F3_W      = 3'b010;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  function automatic logic is_illegal(input logic w, input logic [2:0] f3,
                                      input logic [31:0] a);
    logic bad;
    bad = (a > LAST_ADDR);
    if (w) bad = bad | (f3 > F3_W);
    else   bad = bad | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
`ifdef LSU_MISALIGN_CHECK_EN
    // f3[1:0] encodes the access width for every legal load/store code
    if ((f3[1:0] == 2'b01) && a[0])            bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rd);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{rd[7]}}, rd[7:0]};
      3'b001:  r = {{16{rd[15]}}, rd[15:0]};
      3'b100:  r = {24'h0, rd[7:0]};
      3'b101:  r = {16'h0, rd[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [31:0] rd,
                                              input logic [31:0] wd);
    return f3[0] ? {rd[31:16], wd[15:0]} : {rd[31:8], wd[7:0]};
  endfunction

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_error  = 1'b0;
    mem_we      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_address;
          buf_d    = req_wdata;
          rdata_d  = '0;
          error_d  = 1'b0;
          if (is_illegal(req_write, req_funct3, req_address)) begin
            error_d = 1'b1;
            state_d = RESP;
          end else if (req_write && (req_funct3 == F3_W)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_address = addr_q;
        if (write_q) begin
          buf_d   = store_merge(funct3_q, mem_data_out, buf_q);
          state_d = WRITE;
        end else begin
          rdata_d = load_extend(funct3_q, mem_data_out);
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_we      = 1'b1;
        mem_address = addr_q;
        mem_data_in = buf_q;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_error = error_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are forced quiet the moment reset asserts, before any clock edge.
    if (!reset) begin
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_rdata  = '0;
      resp_error  = 1'b0;
      mem_we      = 1'b0;
      mem_address = '0;
      mem_data_in = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural byte memory and a reference memory image.
module tb_load_store_unit;

  localparam int MEM_BYTES = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_address = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_we(mem_we), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  logic [7:0]  tb_mem  [MEM_BYTES] = '{default: 8'h00};
  logic [7:0]  ref_mem [MEM_BYTES] = '{default: 8'h00};
  logic        we_s = 1'b0;
  logic [31:0] wa_s = '0;
  logic [31:0] wd_s = '0;
  int          we_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always_comb begin
    mem_data_out = '0;
    if (mem_address <= 32'(MEM_BYTES - 4))
      for (int k = 0; k < 4; k++) mem_data_out[8*k +: 8] = tb_mem[int'(mem_address[5:0]) + k];
  end

  always @(negedge clock) begin
    we_s <= mem_we;
    wa_s <= mem_address;
    wd_s <= mem_data_in;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  always @(posedge clock) begin
    if (we_s && reset && (wa_s <= 32'(MEM_BYTES - 4)))
      for (int k = 0; k < 4; k++) tb_mem[int'(wa_s[5:0]) + k] <= wd_s[8*k +: 8];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
    logic        nwe;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd);
    exp_t        e;
    logic        bad;
    logic [31:0] rd;
    int          ai;
    int          nb;
    e.rdata = '0; e.err = 1'b0; e.lat = 4'd1; e.nwe = 1'b0;
    bad = a > 32'(MEM_BYTES - 4);
    if (w) begin
      if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) bad = 1'b1;
    end else begin
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) bad = 1'b1;
    end
`ifdef LSU_MISALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0] != 1'b0) bad = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
`endif
    if (bad) begin
      e.err = 1'b1;
      return e;
    end
    ai = int'(a[5:0]);
    rd = {ref_mem[ai+3], ref_mem[ai+2], ref_mem[ai+1], ref_mem[ai]};
    if (!w) begin
      e.lat = 4'd2;
      case (f3)
        3'd0:    e.rdata = {{24{rd[7]}}, rd[7:0]};
        3'd1:    e.rdata = {{16{rd[15]}}, rd[15:0]};
        3'd4:    e.rdata = {24'h0, rd[7:0]};
        3'd5:    e.rdata = {16'h0, rd[15:0]};
        default: e.rdata = rd;
      endcase
    end else begin
      e.nwe = 1'b1;
      e.lat = (f3 == 3'd2) ? 4'd2 : 4'd3;
      nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int k = 0; k < nb; k++) ref_mem[ai+k] = wd[8*k +: 8];
    end
    return e;
  endfunction

  task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    exp_t        got;
    int          lat;
    int          we0;
    logic [31:0] held;
    exp_q.push_back(model(w, f3, a, wd));
    lat = 0;
    while (!req_ready && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = wd;
    resp_ready = (hold == 0);
    we0 = we_cnt;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    got = exp_q.pop_front();
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_rdata"}, resp_rdata, got.rdata);
    check({tag, "_error"}, 32'(resp_error), 32'(got.err));
    check({tag, "_latency"}, 32'(lat), 32'(got.lat));
    if (hold > 0) begin
      held = resp_rdata;
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
      req_address = 32'h10; req_wdata = 32'hDEAD_DEAD;
      repeat (hold) begin
        @(posedge clock); #1;
        check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_hold_rdata"}, resp_rdata, held);
        check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clock); #1;
    check({tag, "_we_count"}, 32'(we_cnt - we0), 32'(got.nwe));
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_idle_resp_valid"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_error"}, 32'(resp_error), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_address"}, mem_address, 32'd0);
    check({tag, "_mem_data_in"}, mem_data_in, 32'd0);
  endtask

  function automatic logic [31:0] tb_word(input int ai);
    return {tb_mem[ai+3], tb_mem[ai+2], tb_mem[ai+1], tb_mem[ai]};
  endfunction

  function automatic logic [31:0] ref_word(input int ai);
    return {ref_mem[ai+3], ref_mem[ai+2], ref_mem[ai+1], ref_mem[ai]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_quiet("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // Extension of stored data
    do_req("sw10",  1'b1, 3'd2, 32'h10, 32'h8000_00FF, 0);
    do_req("lb10",  1'b0, 3'd0, 32'h10, 32'h0, 0);
    do_req("lbu10", 1'b0, 3'd4, 32'h10, 32'h0, 0);
    do_req("lw10",  1'b0, 3'd2, 32'h10, 32'h0, 0);
    do_req("lh12",  1'b0, 3'd1, 32'h12, 32'h0, 0);
    do_req("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, 0);

    // Sub-word read-modify-write
    do_req("sw20",  1'b1, 3'd2, 32'h20, 32'h1122_3344, 0);
    do_req("sb20",  1'b1, 3'd0, 32'h20, 32'hFFFF_FFAB, 0);
    do_req("lw20a", 1'b0, 3'd2, 32'h20, 32'h0, 0);
    do_req("sh20",  1'b1, 3'd1, 32'h20, 32'h1234_BEEF, 0);
    do_req("lw20b", 1'b0, 3'd2, 32'h20, 32'h0, 0);

    // Reset while an SB is in its write cycle
    do_req("sw30", 1'b1, 3'd2, 32'h30, 32'hCAFE_BABE, 0);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
    req_address = 32'h30; req_wdata = 32'h0000_0055;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("rmw_we_before_reset", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check_quiet("rmw_reset");
    @(posedge clock); #1;
    check_quiet("rmw_reset_held");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rmw_mem_unchanged", tb_word(32'h30), 32'hCAFE_BABE);
    do_req("lw30", 1'b0, 3'd2, 32'h30, 32'h0, 0);

    // Bounds and illegal encodings
    do_req("sw60",   1'b1, 3'd2, 32'd60, 32'h5A5A_A5A5, 0);
    do_req("lw60",   1'b0, 3'd2, 32'd60, 32'h0, 0);
    do_req("lw61",   1'b0, 3'd2, 32'd61, 32'h0, 0);
    do_req("sb61",   1'b1, 3'd0, 32'd61, 32'h0000_0077, 0);
    do_req("lwhigh", 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0, 0);
    do_req("ld011",  1'b0, 3'd3, 32'h0, 32'h0, 0);
    do_req("st100",  1'b1, 3'd4, 32'h0, 32'h1234_5678, 0);

    // Back-pressure on the response
    do_req("lwhold", 1'b0, 3'd2, 32'h10, 32'h0, 5);

    // Misaligned word load
    do_req("lw11", 1'b0, 3'd2, 32'h11, 32'h0, 0);
    do_req("sh21", 1'b1, 3'd1, 32'h21, 32'h0000_7766, 0);

    for (int ai = 0; ai < MEM_BYTES; ai += 4)
      check($sformatf("mem_%02h", ai), tb_word(ai), ref_word(ai));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
